// File: rtl/mt_thread_sched.sv
// Barrel-processor thread scheduler.
// Holds one PC per hardware thread and issues one (thread ID, PC) pair per
// cycle, rotating round-robin over enabled threads. Execute-stage redirects
// overwrite a thread's PC and exclude that thread from selection in the
// same cycle, so a stale PC is never issued.
module mt_thread_sched #(
    parameter int                    NUM_THREADS      = 8,
    parameter int                    DATA_WIDTH       = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC         = 32'h0000_0000,
    parameter logic [DATA_WIDTH-1:0] THREAD_PC_OFFSET = 32'h0000_0100
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           stall,
    input  logic [NUM_THREADS-1:0]         thread_en,
    input  logic                           redirect_valid,
    input  logic [$clog2(NUM_THREADS)-1:0] redirect_tid,
    input  logic [DATA_WIDTH-1:0]          redirect_pc,
    output logic                           issue_valid,
    output logic [$clog2(NUM_THREADS)-1:0] issue_tid,
    output logic [DATA_WIDTH-1:0]          issue_pc
);

    localparam int TID_W = $clog2(NUM_THREADS);

    // Word-aligned redirect target: the two low bits are forced to zero.
    localparam logic [DATA_WIDTH-1:0] ALIGN_MASK = {{(DATA_WIDTH-2){1'b1}}, 2'b00};
    localparam logic [DATA_WIDTH-1:0] PC_STEP    = DATA_WIDTH'(3'd4);

    logic [DATA_WIDTH-1:0]  pc_r [NUM_THREADS];
    logic [TID_W-1:0]       last_tid_r;
    logic [NUM_THREADS-1:0] elig_s;
    logic [TID_W-1:0]       cand_s;
    logic [TID_W-1:0]       sel_s;
    logic                   found_s;
    logic [DATA_WIDTH-1:0]  redirect_pc_aligned_s;

    assign redirect_pc_aligned_s = redirect_pc & ALIGN_MASK;

    // Eligibility: enabled and not being redirected this cycle.
    always_comb begin
        elig_s = '0;
        for (int t = 0; t < NUM_THREADS; t++) begin
            elig_s[t] = thread_en[t] & ~(redirect_valid & (redirect_tid == TID_W'(t)));
        end
    end

    // Round-robin search starting just after the last issued thread, with wrap.
    always_comb begin
        sel_s   = '0;
        found_s = 1'b0;
        cand_s  = '0;
        for (int i = 1; i <= NUM_THREADS; i++) begin
            // TID_W-bit addition wraps naturally because NUM_THREADS is a power of two.
            cand_s = last_tid_r + TID_W'(i);
            if (!found_s && elig_s[cand_s]) begin
                found_s = 1'b1;
                sel_s   = cand_s;
            end else begin
                found_s = found_s;
                sel_s   = sel_s;
            end
        end
    end

    // Per-thread PC state: reset spacing, redirect writes, post-issue increment.
    always_ff @(posedge clk) begin
        for (int t = 0; t < NUM_THREADS; t++) begin
            if (!rst_n) begin
                pc_r[t] <= RESET_PC + (DATA_WIDTH'(t) * THREAD_PC_OFFSET);
            end else if (redirect_valid && (redirect_tid == TID_W'(t))) begin
                pc_r[t] <= redirect_pc_aligned_s;
            end else if (!stall && found_s && (sel_s == TID_W'(t))) begin
                pc_r[t] <= pc_r[t] + PC_STEP;
            end else begin
                pc_r[t] <= pc_r[t];
            end
        end
    end

    // Issue registers and round-robin pointer; stall freezes all of them.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_tid_r  <= TID_W'(NUM_THREADS - 1);
            issue_valid <= 1'b0;
            issue_tid   <= '0;
            issue_pc    <= '0;
        end else if (stall) begin
            last_tid_r  <= last_tid_r;
            issue_valid <= issue_valid;
            issue_tid   <= issue_tid;
            issue_pc    <= issue_pc;
        end else if (found_s) begin
            last_tid_r  <= sel_s;
            issue_valid <= 1'b1;
            issue_tid   <= sel_s;
            issue_pc    <= pc_r[sel_s];
        end else begin
            last_tid_r  <= last_tid_r;
            issue_valid <= 1'b0;
            issue_tid   <= issue_tid;
            issue_pc    <= issue_pc;
        end
    end

endmodule
